// File: rtl/feedback_drivers.sv
// Turns one-cycle event pulses from the pet core into timed buzzer beep patterns
// and active-low status LEDs, plus an independent blink for the critical state.
module feedback_drivers #(
  parameter int TONE_HALF  = 25000,
  parameter int BEEP_CYC   = 5000000,
  parameter int GAP_CYC    = 5000000,
  parameter int BLINK_HALF = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev_feed,
  input  logic       ev_heal,
  input  logic       ev_alarm,
  input  logic       alarm_hold,
  input  logic       mute,
  output logic       buzzer,
  output logic [3:0] led_n,
  output logic       busy
);

  localparam int DMAX = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
  localparam int TW   = (TONE_HALF > 1)  ? $clog2(TONE_HALF)  : 1;
  localparam int DW   = (DMAX > 1)       ? $clog2(DMAX)       : 1;
  localparam int BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [TW-1:0] TONE_LAST  = TW'(TONE_HALF - 1);
  localparam logic [DW-1:0] BEEP_LAST  = DW'(BEEP_CYC - 1);
  localparam logic [DW-1:0] GAP_LAST   = DW'(GAP_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {S_IDLE, S_BEEP, S_GAP} state_t;

  state_t          r_state;
  logic [2:0]      r_pend;       // {alarm, heal, feed}
  logic [2:0]      r_type;       // one-hot type of the pattern playing, 0 when idle
  logic [1:0]      r_beeps;
  logic [DW-1:0]   r_dur;
  logic [TW-1:0]   r_tone;
  logic            r_tone_lvl;
  logic            r_buzz;
  logic            r_busy;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_blink_led;
  logic            r_blink_on;

  logic [2:0] w_ev;
  logic [2:0] w_cand;
  logic [2:0] w_sel;
  logic [2:0] w_clr;
  logic [1:0] w_nbeeps;
  logic       w_beep_end;
  logic       w_gap_end;
  logic       w_launch;

  assign w_ev       = {ev_alarm, ev_heal, ev_feed};
  assign w_cand     = r_pend | w_ev;
  assign w_beep_end = (r_state == S_BEEP) && (r_dur == BEEP_LAST);
  assign w_gap_end  = (r_state == S_GAP)  && (r_dur == GAP_LAST);
  assign w_launch   = (|w_cand) && ((r_state == S_IDLE) || (w_gap_end && r_beeps == 2'd0));
  assign w_clr      = w_sel & {3{w_launch}};

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    w_sel    = 3'b000;
    w_nbeeps = 2'd1;
    if (w_cand[2]) begin
      w_sel    = 3'b100;
      w_nbeeps = 2'd3;
    end else if (w_cand[1]) begin
      w_sel    = 3'b010;
      w_nbeeps = 2'd2;
    end else if (w_cand[0]) begin
      w_sel = 3'b001;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pend     <= 3'b000;
      r_type     <= 3'b000;
      r_beeps    <= 2'd0;
      r_dur      <= '0;
      r_tone     <= '0;
      r_tone_lvl <= 1'b0;
      r_buzz     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // A pulse that launches its own pattern is consumed; a fresh pulse on an
      // already-pending type survives the clear and replays.
      r_pend <= (r_pend & ~w_clr) | (w_ev & ~(w_clr & ~r_pend));
      if (w_launch) begin
        r_state    <= S_BEEP;
        r_type     <= w_sel;
        r_beeps    <= w_nbeeps;
        r_dur      <= '0;
        r_tone     <= '0;
        r_tone_lvl <= 1'b1;
        r_buzz     <= ~mute;
        r_busy     <= 1'b1;
      end else begin
        case (r_state)
          S_BEEP: begin
            if (w_beep_end) begin
              r_state    <= S_GAP;
              r_beeps    <= r_beeps - 2'd1;
              r_dur      <= '0;
              r_tone     <= '0;
              r_tone_lvl <= 1'b0;
              r_buzz     <= 1'b0;
            end else begin
              r_dur <= r_dur + DW'(1);
              if (r_tone == TONE_LAST) begin
                r_tone     <= '0;
                r_tone_lvl <= ~r_tone_lvl;
                r_buzz     <= ~r_tone_lvl & ~mute;
              end else begin
                r_tone <= r_tone + TW'(1);
                r_buzz <= r_tone_lvl & ~mute;
              end
            end
          end
          S_GAP: begin
            if (w_gap_end && r_beeps != 2'd0) begin
              r_state    <= S_BEEP;
              r_dur      <= '0;
              r_tone     <= '0;
              r_tone_lvl <= 1'b1;
              r_buzz     <= ~mute;
            end else if (w_gap_end) begin
              r_state <= S_IDLE;
              r_type  <= 3'b000;
              r_dur   <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_dur <= r_dur + DW'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_type  <= 3'b000;
            r_dur   <= '0;
            r_buzz  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Critical blink runs on its own, independent of the pattern player.
  always_ff @(posedge clk) begin
    if (!rst || !alarm_hold) begin
      r_blink_cnt <= '0;
      r_blink_led <= 1'b1;
      r_blink_on  <= 1'b0;
    end else if (!r_blink_on) begin
      r_blink_cnt <= '0;
      r_blink_led <= 1'b0;
      r_blink_on  <= 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink_led <= ~r_blink_led;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  assign buzzer = r_buzz;
  assign busy   = r_busy;
  assign led_n  = {r_blink_led, ~r_type};

endmodule

// File: doc/feedback_drivers.md
Name: feedback_drivers

Overview:
Output-side counterpart to the Tamagotchi input conditioning. It converts one-cycle event pulses from the pet core FSM (feed and heal acknowledges, alarm) into physical feedback. Feedback takes two forms: timed beep patterns on a piezo buzzer, and active-low status LEDs. It sits between the core FSM and the FPGA pins, alongside the sensor and button drivers.

Parameters:
TONE_HALF, 25000, clk cycles per buzzer half-period (1 kHz at 50 MHz)
BEEP_CYC, 5000000, clk cycles per beep (100 ms)
GAP_CYC, 5000000, clk cycles of silence after every beep, including the last
BLINK_HALF, 12500000, clk cycles per half-period of the alarm_hold blink

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
ev_feed  input  1  one-cycle pulse; requests a 1-beep pattern
ev_heal  input  1  one-cycle pulse; requests a 2-beep pattern
ev_alarm  input  1  one-cycle pulse; requests a 3-beep pattern
alarm_hold  input  1  level; pet critical, blink LED 3
mute  input  1  level; forces buzzer low, pattern timing unchanged
buzzer  output  1  square-wave drive to piezo
led_n  output  4  active-low LEDs: [0] feed, [1] heal, [2] alarm, [3] critical blink
busy  output  1  high while any pattern is playing

Behaviour:
- Reset (rst=0 at a clk edge) sets the following; pending events are lost and event pulses in reset cycles are ignored:
  - buzzer=0, led_n=4'b1111, busy=0
  - pending flags cleared, state IDLE
  - tone, duration and blink counters at 0
- Pending flags, one per type (feed, heal, alarm):
  - set on the edge after the type's pulse
  - cleared on the edge where that type's pattern is launched
  - if set and clear coincide for the same type, set wins (the pattern will replay)
- Selection priority: alarm > heal > feed. The candidates are pending flags OR'd with the same-cycle pulses.
- State machine IDLE -> BEEP -> GAP -> (BEEP | next pattern | IDLE); beeps_left counts 3/2/1 by type.
  - IDLE: if any candidate exists, launch on the next edge: enter BEEP, busy=1, load beeps_left. Latency from pulse to busy/buzzer is 1 cycle.
  - BEEP: lasts exactly BEEP_CYC cycles, then GAP. beeps_left decrements on BEEP exit.
  - GAP: lasts exactly GAP_CYC cycles, buzzer=0.
    - On exit with beeps_left>0: BEEP.
    - On exit with beeps_left=0 and a candidate: launch the next pattern directly into BEEP; busy stays 1 with no idle cycle.
    - Otherwise: IDLE, busy=0.
  - Pattern duration is N*(BEEP_CYC+GAP_CYC) cycles.
- Buzzer:
  - During BEEP, buzzer=1 on the first BEEP cycle and toggles every TONE_HALF cycles. The tone counter restarts at each BEEP entry.
  - Outside BEEP, buzzer=0.
  - mute=1 forces buzzer=0 combinationally-registered (same cycle timing as the unmuted output); mute has no effect on state or counters.
- Pattern LEDs: led_n[0..2] are low exactly while the matching pattern is playing (BEEP and GAP of that pattern); otherwise high.
- Blink LED 3:
  - While alarm_hold=1, led_n[3] starts low on the first cycle after alarm_hold rises and toggles every BLINK_HALF cycles.
  - alarm_hold=0 drives led_n[3]=1 and blink counter=0 on the next edge.
  - The blink counter is independent of the pattern FSM.
- Events arriving while busy:
  - latched as pending and never dropped
  - a repeated event of the same type while already pending is merged (single replay)
- Counter widths: each counter is sized with $clog2 of its parameter. Counters reset to 0 at every state entry. No wrap beyond terminal count.
- Reset mid-pattern: the next edge reaches the reset state, and the aborted pattern does not resume.

Test Plan:
(Bench parameters: TONE_HALF=2, BEEP_CYC=8, GAP_CYC=4, BLINK_HALF=5.)
1. Reset: hold rst=0 for 3 cycles while pulsing all events -> buzzer=0, led_n=1111, busy=0. After release with no further events, busy stays 0.
2. Single feed: ev_feed pulse in cycle 0 -> busy=1 in cycles 1-12.
   - buzzer = 1,1,0,0,1,1,0,0 in cycles 1-8, then 0 in cycles 9-12
   - led_n=1110 in cycles 1-12; all idle at cycle 13
3. Priority and queueing: ev_feed and ev_alarm pulse in the same cycle 0 -> alarm plays in cycles 1-36 (led_n=1011, three 8-cycle beeps), then feed plays in cycles 37-48 (led_n=1110). busy is continuously 1 in cycles 1-48.
4. Mute: mute=1 throughout, ev_heal pulse -> buzzer=0 always, busy=1 for 24 cycles, led_n[1]=0 for those 24 cycles.
5. Blink: alarm_hold rises in cycle 0 -> led_n[3]=0 in cycles 1-5, 1 in cycles 6-10, 0 from cycle 11. Dropping alarm_hold -> led_n[3]=1 on the next cycle.
6. Reset mid-pattern: ev_alarm, then rst=0 in cycle 15 while an ev_feed is pending -> all outputs at reset values in cycle 16. Nothing plays after release.
